apb_master: RTL

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/apb_master.sv
// Single-outstanding APB master: host command in, one APB transfer out, one-cycle response pulse.
// Optional ACCESS-phase timeout abort is compiled in with `define APB_TIMEOUT_EN.
module apb_master #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        PSEL,
   output logic        PENABLE,
   output logic        PWRITE,
   output logic [31:0] PRWADDR,
   output logic [31:0] PRWDATA,
   input  logic [31:0] PRDATA1,
   input  logic        PREADY,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t state;
   state_t next_state;
   logic   accept;
   logic   done;
   logic   finish;

`ifdef APB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);
   logic [CW-1:0] tcnt;
   logic          timeout_hit;
`endif

   // Idle is the only state that takes a command; reset masks it immediately.
   assign cmd_ready = (state == IDLE) && !PRESET;

   // State register.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode; PREADY only matters in ACCESS.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      done       = 1'b0;
      finish     = 1'b0;
`ifdef APB_TIMEOUT_EN
      timeout_hit = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               accept     = 1'b1;
               next_state = SETUP;
            end else begin
               next_state = IDLE;
            end
         end
         SETUP: begin
            next_state = ACCESS;
         end
         ACCESS: begin
            if (PREADY) begin
               done       = 1'b1;
               finish     = 1'b1;
               next_state = IDLE;
            end
`ifdef APB_TIMEOUT_EN
            // A late PREADY on the final count still wins over the abort.
            else if (tcnt == TMAX) begin
               timeout_hit = 1'b1;
               finish      = 1'b1;
               next_state  = IDLE;
            end
`endif
            else begin
               next_state = ACCESS;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Registered APB request and response outputs.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PRWADDR   <= 32'd0;
         PRWDATA   <= 32'd0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
      end else begin
         PSEL      <= (next_state != IDLE);
         PENABLE   <= (next_state == ACCESS);
         rsp_valid <= finish;
         if (accept) begin
            PWRITE  <= cmd_write;
            PRWADDR <= cmd_addr;
            PRWDATA <= cmd_wdata;
         end else begin
            PWRITE  <= PWRITE;
            PRWADDR <= PRWADDR;
            PRWDATA <= PRWDATA;
         end
         if (done && !PWRITE) begin
            rsp_rdata <= PRDATA1;
         end else begin
            rsp_rdata <= rsp_rdata;
         end
      end
   end

`ifdef APB_TIMEOUT_EN
   // Counts ACCESS wait states; cleared every SETUP.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         tcnt    <= '0;
         rsp_err <= 1'b0;
      end else begin
         rsp_err <= timeout_hit;
         if (state == SETUP) begin
            tcnt <= '0;
         end else if (state == ACCESS && !PREADY) begin
            tcnt <= tcnt + 1'b1;
         end else begin
            tcnt <= tcnt;
         end
      end
   end
`else
   assign rsp_err = 1'b0;
`endif

endmodule
